melody_player: RTL and testbench



---
 rtl/melody_pkg.sv | 98 +++++++++
 rtl/melody_player_tone_gen.sv | 39 +++
 rtl/melody_player.sv | 151 +++++++++++++++
 tb/tb_melody_player.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
// Module   : melody_pkg
// Brief    : State/entry types, note codes, 50 MHz half-period LUT and song ROM
//            shared by the melody player.
// Revision : 1.0
// ============================================================================
package melody_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [4:0] note;
        logic [2:0] beats;
    } entry_t;

    localparam logic [4:0] NOTE_REST = 5'd0;
    localparam logic [4:0] NOTE_C4   = 5'd1;
    localparam logic [4:0] NOTE_D4   = 5'd2;
    localparam logic [4:0] NOTE_E4   = 5'd3;
    localparam logic [4:0] NOTE_F4   = 5'd4;
    localparam logic [4:0] NOTE_G4   = 5'd5;
    localparam logic [4:0] NOTE_A4   = 5'd6;
    localparam logic [4:0] NOTE_B4   = 5'd7;
    localparam logic [4:0] NOTE_C5   = 5'd8;
    localparam logic [4:0] NOTE_D5   = 5'd9;
    localparam logic [4:0] NOTE_E5   = 5'd10;
    localparam logic [4:0] NOTE_F5   = 5'd11;
    localparam logic [4:0] NOTE_G5   = 5'd12;
    localparam logic [4:0] NOTE_A5   = 5'd13;
    localparam logic [4:0] NOTE_B5   = 5'd14;
    localparam logic [4:0] NOTE_C6   = 5'd15;
    localparam logic [4:0] NOTE_D6   = 5'd16;
    localparam logic [4:0] NOTE_E6   = 5'd17;
    localparam logic [4:0] NOTE_F6   = 5'd18;
    localparam logic [4:0] NOTE_G6   = 5'd19;
    localparam logic [4:0] NOTE_A6   = 5'd20;
    localparam logic [4:0] NOTE_B6   = 5'd21;
    localparam logic [4:0] NOTE_END  = 5'd31;

    // Half-period in 50 MHz cycles: 25e6 / f, rounded.
    function automatic logic [31:0] lut_half(input logic [4:0] note);
        case (note)
            NOTE_C4: lut_half = 32'd95556;
            NOTE_D4: lut_half = 32'd85131;
            NOTE_E4: lut_half = 32'd75843;
            NOTE_F4: lut_half = 32'd71586;
            NOTE_G4: lut_half = 32'd63776;
            NOTE_A4: lut_half = 32'd56818;
            NOTE_B4: lut_half = 32'd50619;
            NOTE_C5: lut_half = 32'd47778;
            NOTE_D5: lut_half = 32'd42566;
            NOTE_E5: lut_half = 32'd37921;
            NOTE_F5: lut_half = 32'd35793;
            NOTE_G5: lut_half = 32'd31888;
            NOTE_A5: lut_half = 32'd28409;
            NOTE_B5: lut_half = 32'd25310;
            NOTE_C6: lut_half = 32'd23889;
            NOTE_D6: lut_half = 32'd21283;
            NOTE_E6: lut_half = 32'd18961;
            NOTE_F6: lut_half = 32'd17896;
            NOTE_G6: lut_half = 32'd15944;
            NOTE_A6: lut_half = 32'd14205;
            NOTE_B6: lut_half = 32'd12655;
            default: lut_half = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] half_period(input logic [4:0] note,
                                                input int unsigned div);
        logic [31:0] q;
        q = lut_half(note) / div;
        half_period = (q == 32'd0) ? 32'd1 : q;
    endfunction

    function automatic logic [31:0] dur_cycles(input logic [2:0] beats,
                                               input int unsigned beat_cycles,
                                               input int unsigned gap_cycles);
        dur_cycles = (32'(beats) + 32'd1) * beat_cycles - gap_cycles;
    endfunction

    function automatic entry_t rom_entry(input logic [4:0] idx);
        case (idx)
            5'd0:    rom_entry = '{note: NOTE_E5,   beats: 3'd0};
            5'd1:    rom_entry = '{note: NOTE_G5,   beats: 3'd0};
            5'd2:    rom_entry = '{note: NOTE_REST, beats: 3'd0};
            5'd3:    rom_entry = '{note: NOTE_C6,   beats: 3'd1};
            default: rom_entry = '{note: NOTE_END,  beats: 3'd0};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/melody_player_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : tone_gen
// Brief    : Half-period down-counter and toggle flop; idles high when muted.
// Revision : 1.0
// ============================================================================
module tone_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] half_period,
    input  logic        mute,
    output logic        out
);

    logic [31:0] r_cnt;
    logic        r_tog;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_tog <= 1'b1;
        end else if (load) begin
            r_cnt <= half_period;
            r_tog <= 1'b1;
        end else if (mute) begin
            r_tog <= 1'b1;
        end else if (r_cnt == 32'd0) begin
            r_cnt <= half_period;
            r_tog <= ~r_tog;
        end else begin
            r_cnt <= r_cnt - 32'd1;
        end
    end

    assign out = r_tog;

endmodule
`default_nettype wire

// File: rtl/melody_player.sv
`default_nettype none
// ============================================================================
// Module   : melody_player
// Brief    : Victory-melody sequencer feeding the buzzer path. Define
//            MELODY_LOOP_EN to repeat the song while en stays high.
// Revision : 1.0
// ============================================================================
module melody_player
    import melody_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 6250000,
    parameter int unsigned GAP_CYCLES  = 500000,
    parameter int unsigned TONE_DIV    = 1,
    parameter int unsigned SONG_LEN    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       out,
    output logic       busy,
    output logic [4:0] note_idx
);

`ifdef MELODY_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_idx, w_idx_nxt, w_idx_inc;
    logic [31:0] r_dur, w_dur_nxt;
    logic [31:0] r_gap, w_gap_nxt;
    logic        w_load, w_song_end, w_mute;
    entry_t      w_cur, w_first, w_next_entry, w_entry_sel;
    logic [31:0] w_hp;

    assign w_cur        = rom_entry(r_idx);
    assign w_first      = rom_entry(5'd0);
    assign w_idx_inc    = r_idx + 5'd1;
    assign w_next_entry = rom_entry(w_idx_inc);
    assign w_song_end   = (r_idx == 5'(SONG_LEN - 1)) || (w_next_entry.note == NOTE_END);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_dur_nxt   = r_dur;
        w_gap_nxt   = r_gap;
        w_load      = 1'b0;
        w_entry_sel = w_cur;

        case (r_state)
            IDLE: begin
                if (en) begin
                    w_idx_nxt = 5'd0;
                    if (w_first.note == NOTE_END) begin
                        // Empty song: nothing to play, so never enter PLAY.
                        w_state_nxt = LOOP_EN ? IDLE : DONE;
                    end else begin
                        w_state_nxt = PLAY;
                        w_load      = 1'b1;
                        w_entry_sel = w_first;
                    end
                end
            end
            PLAY: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 5'd0;
                end else begin
                    w_dur_nxt = (r_dur != 32'd0) ? r_dur - 32'd1 : 32'd0;
                    if (r_dur <= 32'd1) begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = GAP_CYCLES;
                    end
                end
            end
            GAP: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 5'd0;
                end else begin
                    w_gap_nxt = (r_gap != 32'd0) ? r_gap - 32'd1 : 32'd0;
                    if (r_gap <= 32'd1) begin
                        if (!w_song_end) begin
                            w_state_nxt = PLAY;
                            w_idx_nxt   = w_idx_inc;
                            w_load      = 1'b1;
                            w_entry_sel = w_next_entry;
                        end else if (LOOP_EN) begin
                            w_state_nxt = PLAY;
                            w_idx_nxt   = 5'd0;
                            w_load      = 1'b1;
                            w_entry_sel = w_first;
                        end else begin
                            w_state_nxt = DONE;
                            w_idx_nxt   = w_idx_inc;
                        end
                    end
                end
            end
            DONE: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 5'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 5'd0;
            end
        endcase

        if (w_load) begin
            w_dur_nxt = dur_cycles(w_entry_sel.beats, BEAT_CYCLES, GAP_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 5'd0;
            r_dur   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_dur   <= w_dur_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // Muting is decided on the next state so out is already high on the
    // first GAP/IDLE cycle, with no combinational path to the buzzer.
    assign w_hp   = half_period(w_entry_sel.note, TONE_DIV);
    assign w_mute = (w_state_nxt != PLAY) || (w_cur.note == NOTE_REST);

    tone_gen u_tone (
        .clk         (clk),
        .rst         (rst),
        .load        (w_load),
        .half_period (w_hp),
        .mute        (w_mute),
        .out         (out)
    );

    assign busy     = (r_state == PLAY) || (r_state == GAP);
    assign note_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_melody_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_melody_player
// Brief    : Self-checking bench: directed vector table, hand-written abort and
//            reset sequences, and randomized en/rst against a timeline model.
// Revision : 1.0
// ============================================================================
module tb_melody_player;

    localparam int BEAT = 100;
    localparam int GAPC = 10;
    localparam int DIV  = 1000;
    localparam int N_NOTES = 4;
    localparam int END_IDX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       out;
    logic       busy;
    logic [4:0] note_idx;

    always #5 clk = ~clk;

    melody_player #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAPC),
        .TONE_DIV    (DIV),
        .SONG_LEN    (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .out      (out),
        .busy     (busy),
        .note_idx (note_idx)
    );

    // Song as written down from the melody description (rest has no LUT value).
    int lut_tab  [N_NOTES] = '{37921, 31888, 0, 23889};
    int beat_tab [N_NOTES] = '{0, 0, 0, 1};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic eo, input logic eb,
                         input logic [4:0] ei);
        n_checks++;
        if (out === eo && busy === eb && note_idx === ei) n_pass++;
        else $display("FAIL %s: got out=%0b busy=%0b idx=%0d, expected out=%0b busy=%0b idx=%0d",
                      name, out, busy, note_idx, eo, eb, ei);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- timeline reference model ----------------
    int m_mode;   // 0 idle, 1 playing, 2 finished
    int m_tau;    // cycles since first PLAY cycle of entry 0

    function automatic int song_total();
        int t = 0;
        for (int i = 0; i < N_NOTES; i++) t += (beat_tab[i] + 1) * BEAT;
        return t;
    endfunction

    task automatic model_step(input logic r, input logic e);
        if (r) m_mode = 0;
        else begin
            case (m_mode)
                0: if (e) begin m_mode = 1; m_tau = 0; end
                1: begin
                    if (!e) m_mode = 0;
                    else begin
                        m_tau++;
                        if (m_tau >= song_total()) begin
`ifdef MELODY_LOOP_EN
                            m_tau = 0;
`else
                            m_mode = 2;
`endif
                        end
                    end
                end
                default: if (!e) m_mode = 0;
            endcase
        end
    endtask

    task automatic model_expect(output logic eo, output logic eb, output logic [4:0] ei);
        int t, len, hp;
        bit found;
        eo = 1'b1; eb = 1'b0; ei = 5'd0;
        if (m_mode == 2) ei = 5'(END_IDX);
        else if (m_mode == 1) begin
            t = m_tau;
            found = 0;
            for (int i = 0; i < N_NOTES; i++) begin
                len = (beat_tab[i] + 1) * BEAT;
                if (!found && t < len) begin
                    found = 1;
                    eb = 1'b1;
                    ei = 5'(i);
                    hp = lut_tab[i] / DIV;
                    if (hp < 1) hp = 1;
                    if (lut_tab[i] == 0 || t >= len - GAPC) eo = 1'b1;
                    else eo = ((t / (hp + 1)) % 2 == 0);
                end else if (!found) t -= len;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        int         cycles;
        logic       each;
        logic       eo;
        logic       eb;
        logic [4:0] ei;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string nm, input logic r, input logic e, input int c,
                                input logic ea, input logic o, input logic b, input logic [4:0] i);
        vec_t v;
        v.name = nm; v.rst = r; v.en = e; v.cycles = c; v.each = ea;
        v.eo = o; v.eb = b; v.ei = i;
        tbl.push_back(v);
    endfunction

    logic       x_o, x_b;
    logic [4:0] x_i;
    int         r_val;

    initial begin
        rst = 1'b1;
        en  = 1'b0;

        add("reset",       1, 0,   3, 1, 1, 0, 0);
        add("idle",        0, 0, 100, 1, 1, 0, 0);
        add("start",       0, 1,   1, 0, 1, 1, 0);
        add("e0_k37",      0, 1,  37, 0, 1, 1, 0);
        add("e0_k38",      0, 1,   1, 0, 0, 1, 0);
        add("e0_k75",      0, 1,  37, 0, 0, 1, 0);
        add("e0_k76",      0, 1,   1, 0, 1, 1, 0);
        add("e0_k89",      0, 1,  13, 0, 1, 1, 0);
        add("e0_gap",      0, 1,   1, 0, 1, 1, 0);
        add("e0_gap_end",  0, 1,   9, 0, 1, 1, 0);
        add("e1_start",    0, 1,   1, 0, 1, 1, 1);
        add("e1_k32",      0, 1,  32, 0, 0, 1, 1);
        add("e1_gap",      0, 1,  58, 0, 1, 1, 1);
        add("e2_start",    0, 1,  10, 0, 1, 1, 2);
        add("e2_rest",     0, 1,  90, 1, 1, 1, 2);
        add("e3_start",    0, 1,  10, 0, 1, 1, 3);
        add("e3_k23",      0, 1,  23, 0, 1, 1, 3);
        add("e3_k24",      0, 1,   1, 0, 0, 1, 3);
        add("e3_gap",      0, 1, 166, 0, 1, 1, 3);
        add("e3_gap_end",  0, 1,   9, 0, 1, 1, 3);
`ifdef MELODY_LOOP_EN
        add("loop_wrap",   0, 1,   1, 0, 1, 1, 0);
        add("loop_k38",    0, 1,  38, 0, 0, 1, 0);
`else
        add("done",        0, 1,   1, 0, 1, 0, 4);
        add("done_hold",   0, 1,  20, 1, 1, 0, 4);
`endif
        add("release",     0, 0,   1, 0, 1, 0, 0);

        foreach (tbl[v]) begin
            rst = tbl[v].rst;
            en  = tbl[v].en;
            if (tbl[v].each) begin
                for (int c = 0; c < tbl[v].cycles; c++) begin
                    step(1);
                    check(tbl[v].name, tbl[v].eo, tbl[v].eb, tbl[v].ei);
                end
            end else begin
                step(tbl[v].cycles);
                check(tbl[v].name, tbl[v].eo, tbl[v].eb, tbl[v].ei);
            end
        end

        // Abort mid-note at entry 1, then restart from entry 0.
        en = 1'b1; step(1);   check("ab_start",   1, 1, 0);
        step(120);            check("ab_e1_k20",  1, 1, 1);
        en = 1'b0; step(1);   check("ab_idle",    1, 0, 0);
        en = 1'b1; step(1);   check("ab_restart", 1, 1, 0);
        step(38);             check("ab_k38",     0, 1, 0);

        // Reset during the gap of entry 1 with en held high.
        step(152);            check("rs_gap",     1, 1, 1);
        step(3);
        rst = 1'b1; step(1);  check("rs_idle",    1, 0, 0);
        step(1);              check("rs_hold",    1, 0, 0);
        rst = 1'b0; step(1);  check("rs_replay",  1, 1, 0);
        step(38);             check("rs_k38",     0, 1, 0);

        // Randomized en/rst against the timeline model.
        rst = 1'b1; en = 1'b0; step(2);
        m_mode = 0; m_tau = 0;
        rst = 1'b0;
        for (int n = 0; n < 8000; n++) begin
            r_val = $urandom_range(0, 999);
            if (r_val < 2) en = ~en;
            rst = (r_val == 999);
            step(1);
            model_step(rst, en);
            model_expect(x_o, x_b, x_i);
            check("random", x_o, x_b, x_i);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
